// File: rtl/crc_serial_if.sv
// crc_serial_if: control strobes and status bundle of the serial CRC engine.
interface crc_serial_if #(
  parameter int CRC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 12
);
  logic                   clear;
  logic                   shift_en;
  logic                   serial_in;
  logic                   send_crc;
  logic                   serial_out;
  logic                   crc_busy;
  logic                   crc_done;
  logic                   pass;
  logic [CRC_WIDTH-1:0]   crc_value;
  logic [COUNT_WIDTH-1:0] bit_count;
  modport master (
    output clear, shift_en, serial_in, send_crc,
    input  serial_out, crc_busy, crc_done, pass, crc_value, bit_count
  );
  modport slave (
    input  clear, shift_en, serial_in, send_crc,
    output serial_out, crc_busy, crc_done, pass, crc_value, bit_count
  );
endinterface

// File: rtl/crc_serial_unit.sv
// crc_serial_unit: MSB-first serial CRC checker/generator that can shift out its complemented CRC.
module crc_serial_unit #(
  parameter int                   CRC_WIDTH   = 16,
  parameter logic [CRC_WIDTH-1:0] POLY        = 16'h8005,
  parameter logic [CRC_WIDTH-1:0] INIT        = '1,
  parameter logic [CRC_WIDTH-1:0] RESIDUAL    = 16'h800D,
  parameter int                   COUNT_WIDTH = 12
) (
  input logic         clk,
  input logic         rst,
  crc_serial_if.slave bus
);
  localparam int EW = $clog2(CRC_WIDTH + 1);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;
  logic [0:0]             state;
  logic [CRC_WIDTH-1:0]   crc;
  logic [CRC_WIDTH-1:0]   shadow;
  logic [CRC_WIDTH-1:0]   crc_next;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [EW-1:0]          ecnt;
  logic                   done;
  logic                   din;
  logic                   fb;
  // While emitting, the register eats its own output so it ends on the residual.
  assign din      = (state == EMIT) ? shadow[CRC_WIDTH-1] : bus.serial_in;
  assign fb       = crc[CRC_WIDTH-1] ^ din;
  assign crc_next = {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state  <= ACCUM;
      crc    <= INIT;
      shadow <= '0;
      cnt    <= '0;
      ecnt   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ACCUM) begin
        if (bus.send_crc) begin
          shadow <= ~crc;
          ecnt   <= EW'(CRC_WIDTH - 1);
          state  <= EMIT;
        end else if (bus.shift_en) begin
          crc <= crc_next;
          if (!(&cnt)) cnt <= cnt + COUNT_WIDTH'(1);
        end
      end else if (bus.shift_en) begin
        shadow <= shadow << 1;
        crc    <= crc_next;
        if (ecnt == '0) begin
          state <= ACCUM;
          done  <= 1'b1;
        end else begin
          ecnt <= ecnt - EW'(1);
        end
      end
    end
  end
  assign bus.serial_out = (state == EMIT) && shadow[CRC_WIDTH-1];
  assign bus.crc_busy   = (state == EMIT);
  assign bus.crc_done   = done;
  assign bus.pass       = (crc == RESIDUAL);
  assign bus.crc_value  = crc;
  assign bus.bit_count  = cnt;
endmodule

// File: tb/tb_crc_serial_unit.sv
// tb_crc_serial_unit: directed vectors for CRC5 and CRC16 instances of the serial CRC engine.
module tb_crc_serial_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  crc_serial_if #(.CRC_WIDTH(5),  .COUNT_WIDTH(12)) b5a ();
  crc_serial_if #(.CRC_WIDTH(5),  .COUNT_WIDTH(12)) b5b ();
  crc_serial_if #(.CRC_WIDTH(16), .COUNT_WIDTH(12)) b16a ();
  crc_serial_if #(.CRC_WIDTH(16), .COUNT_WIDTH(12)) b16b ();
  crc_serial_unit #(.CRC_WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUAL(5'h0C), .COUNT_WIDTH(12))
    u5a (.clk(clk), .rst(rst), .bus(b5a.slave));
  crc_serial_unit #(.CRC_WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUAL(5'h0C), .COUNT_WIDTH(12))
    u5b (.clk(clk), .rst(rst), .bus(b5b.slave));
  crc_serial_unit u16a (.clk(clk), .rst(rst), .bus(b16a.slave));
  crc_serial_unit u16b (.clk(clk), .rst(rst), .bus(b16b.slave));
  typedef struct {
    logic       clr, snd, sh, si;
    logic [4:0] crc;
    logic       busy, out, done, pass;
    logic [11:0] cnt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic clr, logic snd, logic sh, logic si, logic [4:0] crc,
                             logic busy, logic out, logic done, logic pass, logic [11:0] cnt);
    vec_t r;
    r.clr = clr; r.snd = snd; r.sh = sh; r.si = si; r.crc = crc;
    r.busy = busy; r.out = out; r.done = done; r.pass = pass; r.cnt = cnt;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all;
    {b5a.clear, b5a.send_crc, b5a.shift_en, b5a.serial_in} = '0;
    {b5b.clear, b5b.send_crc, b5b.shift_en, b5b.serial_in} = '0;
    {b16a.clear, b16a.send_crc, b16a.shift_en, b16a.serial_in} = '0;
    {b16b.clear, b16b.send_crc, b16b.shift_en, b16b.serial_in} = '0;
  endtask
  initial begin
    logic [4:0]  tok_crc [11];
    logic [10:0] tok;
    logic [15:0] s5, exp16;
    logic [31:0] s16;
    idle_all();
    tok = 11'h0A1;
    tok_crc = '{5'h1B, 5'h13, 5'h03, 5'h03, 5'h06, 5'h09, 5'h12, 5'h01, 5'h02, 5'h04, 5'h0D};
    tbl.push_back(v(1, 0, 0, 0, 5'h1F, 0, 0, 0, 0, 12'd0));
    for (int i = 0; i < 11; i++)
      tbl.push_back(v(0, 0, 1, tok[10-i], tok_crc[i], 0, 0, 0, 0, 12'(i + 1)));
    tbl.push_back(v(0, 1, 0, 0, 5'h0D, 1, 1, 0, 0, 12'd11));
    tbl.push_back(v(0, 0, 1, 1, 5'h1F, 1, 0, 0, 0, 12'd11));
    tbl.push_back(v(0, 0, 1, 0, 5'h1B, 1, 0, 0, 0, 12'd11));
    tbl.push_back(v(0, 0, 1, 1, 5'h13, 1, 1, 0, 0, 12'd11));
    tbl.push_back(v(0, 0, 1, 0, 5'h06, 1, 0, 0, 0, 12'd11));
    tbl.push_back(v(0, 0, 1, 0, 5'h0C, 0, 0, 1, 1, 12'd11));
    tbl.push_back(v(0, 1, 0, 0, 5'h0C, 1, 1, 0, 1, 12'd11));
    tbl.push_back(v(1, 1, 1, 1, 5'h1F, 0, 0, 0, 0, 12'd0));
    tick(); tick();
    rst = 1'b0;
    chk("rst5_crc", 32'(b5a.crc_value), 32'h1F);
    chk("rst5_pass", 32'(b5a.pass), 0);
    chk("rst5_busy", 32'(b5a.crc_busy), 0);
    chk("rst5_cnt", 32'(b5a.bit_count), 0);
    chk("rst16_crc", 32'(b16a.crc_value), 32'hFFFF);
    // single-bit updates from INIT
    b5a.shift_en = 1; b5a.serial_in = 0;
    b5b.shift_en = 1; b5b.serial_in = 1;
    tick();
    idle_all();
    chk("bit0_crc", 32'(b5a.crc_value), 32'h1B);
    chk("bit1_crc", 32'(b5b.crc_value), 32'h1E);
    chk("bit1_cnt", 32'(b5b.bit_count), 1);
    tick();
    chk("hold_crc", 32'(b5b.crc_value), 32'h1E);
    b5b.clear = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      b5a.clear = tbl[i].clr; b5a.send_crc = tbl[i].snd;
      b5a.shift_en = tbl[i].sh; b5a.serial_in = tbl[i].si;
      tick();
      b5b.clear = 0;
      chk($sformatf("t%0d_crc", i), 32'(b5a.crc_value), 32'(tbl[i].crc));
      chk($sformatf("t%0d_busy", i), 32'(b5a.crc_busy), 32'(tbl[i].busy));
      chk($sformatf("t%0d_out", i), 32'(b5a.serial_out), 32'(tbl[i].out));
      chk($sformatf("t%0d_done", i), 32'(b5a.crc_done), 32'(tbl[i].done));
      chk($sformatf("t%0d_pass", i), 32'(b5a.pass), 32'(tbl[i].pass));
      chk($sformatf("t%0d_cnt", i), 32'(b5a.bit_count), 32'(tbl[i].cnt));
    end
    idle_all();
    // token plus its emitted CRC looped into the checker copy
    s5 = 16'b0001010000110010;
    for (int i = 15; i >= 0; i--) begin
      b5b.shift_en = 1; b5b.serial_in = s5[i];
      tick();
    end
    idle_all();
    chk("loop5_crc", 32'(b5b.crc_value), 32'h0C);
    chk("loop5_pass", 32'(b5b.pass), 1);
    chk("loop5_cnt", 32'(b5b.bit_count), 16);
    // abort: send_crc in EMIT ignored, clear on 3rd emitted bit
    b5a.shift_en = 1; b5a.serial_in = 0;
    tick();
    idle_all();
    b5a.send_crc = 1;
    tick();
    chk("ab_busy", 32'(b5a.crc_busy), 1);
    tick();
    b5a.send_crc = 0;
    chk("ab_resend_crc", 32'(b5a.crc_value), 32'h1B);
    chk("ab_resend_busy", 32'(b5a.crc_busy), 1);
    b5a.shift_en = 1;
    tick();
    chk("ab_e1_crc", 32'(b5a.crc_value), 32'h13);
    tick();
    chk("ab_e2_crc", 32'(b5a.crc_value), 32'h03);
    chk("ab_e2_out", 32'(b5a.serial_out), 1);
    b5a.clear = 1;
    tick();
    idle_all();
    chk("ab_busy0", 32'(b5a.crc_busy), 0);
    chk("ab_crc", 32'(b5a.crc_value), 32'h1F);
    chk("ab_done", 32'(b5a.crc_done), 0);
    chk("ab_cnt", 32'(b5a.bit_count), 0);
    tick();
    chk("ab_done2", 32'(b5a.crc_done), 0);
    // CRC16: bytes 0x00, 0x01, then generate
    s16 = {16'h0001, 16'h0000};
    for (int i = 31; i >= 16; i--) begin
      b16a.shift_en = 1; b16a.serial_in = s16[i];
      tick();
    end
    idle_all();
    chk("c16_crc", 32'(b16a.crc_value), 32'h0008);
    chk("c16_cnt", 32'(b16a.bit_count), 16);
    b16a.send_crc = 1;
    tick();
    b16a.send_crc = 0;
    exp16 = 16'hFFF7;
    for (int i = 15; i >= 0; i--) begin
      chk($sformatf("c16_out%0d", i), 32'(b16a.serial_out), 32'(exp16[i]));
      b16a.shift_en = 1;
      tick();
    end
    idle_all();
    chk("c16_res", 32'(b16a.crc_value), 32'h800D);
    chk("c16_pass", 32'(b16a.pass), 1);
    chk("c16_done", 32'(b16a.crc_done), 1);
    chk("c16_busy", 32'(b16a.crc_busy), 0);
    tick();
    chk("c16_done1", 32'(b16a.crc_done), 0);
    // checker copy with the last data bit flipped
    s16 = {16'h0000, 16'hFFF7};
    for (int i = 31; i >= 0; i--) begin
      b16b.shift_en = 1; b16b.serial_in = s16[i];
      tick();
    end
    idle_all();
    chk("flip_pass", 32'(b16b.pass), 0);
    // bit counter saturation
    b16a.clear = 1;
    tick();
    b16a.clear = 0;
    b16a.shift_en = 1;
    for (int i = 0; i < 4094; i++) tick();
    chk("sat_pre", 32'(b16a.bit_count), 32'hFFE);
    for (int i = 0; i < 5; i++) tick();
    idle_all();
    chk("sat_cnt", 32'(b16a.bit_count), 32'hFFF);
    // reset dominates send_crc and shift_en
    b5a.shift_en = 1; b5a.serial_in = 1;
    tick();
    chk("pre_rst_crc", 32'(b5a.crc_value), 32'h1E);
    rst = 1; b5a.send_crc = 1;
    tick();
    rst = 0;
    idle_all();
    chk("rstc_crc", 32'(b5a.crc_value), 32'h1F);
    chk("rstc_busy", 32'(b5a.crc_busy), 0);
    chk("rstc_cnt", 32'(b5a.bit_count), 0);
    chk("rstc_out", 32'(b5a.serial_out), 0);
    chk("rstc_done", 32'(b5a.crc_done), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
